// File: rtl/dm_read_cache_if.sv
// ---------------------------------------------------------------------------
// dm_read_cache_if
// Bus bundle between the direct-mapped read cache and its environment.
//   Request side : req_valid/req_ready/req_addr, resp_valid/resp_data
//   Refill side  : mem_req_valid/mem_req_ready/mem_addr,
//                  mem_resp_valid/mem_resp_data
//   Snoop side   : wea/addra/dina (writes issued elsewhere to memory)
//   Control      : flush (invalidate every line)
// The slave modport is the cache itself; master is whoever drives it.
// ---------------------------------------------------------------------------
interface dm_read_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  flush;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
           wea, addra, dina, flush,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
           wea, addra, dina, flush,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_addr
  );
endinterface

// File: rtl/dm_read_cache.sv
// ---------------------------------------------------------------------------
// dm_read_cache
// Direct-mapped, single-word-line read cache in front of a word-addressed
// memory. One read in flight at a time; misses refill through a valid/ready
// memory port; the memory write bus is snooped (write-update, no allocate);
// flush clears every valid bit in one cycle (deferred to IDLE if busy).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - dm_read_cache_if.slave (request, response, refill, snoop, flush)
//   hit_count/miss_count - 32-bit saturating lookup counters, present only
//                          when DM_CACHE_STATS_EN is defined
// Optional feature macro: DM_CACHE_STATS_EN
// ---------------------------------------------------------------------------
module dm_read_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 19,
  parameter int INDEX_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  dm_read_cache_if.slave   bus
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 2 ** INDEX_WIDTH;

  // RESP is the registered response stage after the tag compare; it keeps
  // hits at two cycles of latency and one accept every three cycles.
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, MREQ, MWAIT} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINES-1:0]        valid_q;
  logic                    flush_pend_q;
  logic                    wr_pend_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [DATA_WIDTH-1:0]   hit_data_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
  logic                    mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;

  logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES];
  logic [TAG_WIDTH-1:0]    tag_rd_q;
  logic [DATA_WIDTH-1:0]   data_rd_q;

  logic [INDEX_WIDTH-1:0]  idx_q, idx_req, idx_a;
  logic [TAG_WIDTH-1:0]    tag_q, tag_a;
  logic                    flush_now, accept, hit_d, wr_match;
  logic                    snoop_hit, snoop_wr, refill_fire;
  logic                    accept_wr_match;
  logic [DATA_WIDTH-1:0]   refill_data_d;

  assign idx_q   = addr_q[INDEX_WIDTH-1:0];
  assign tag_q   = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign idx_req = bus.req_addr[INDEX_WIDTH-1:0];
  assign idx_a   = bus.addra[INDEX_WIDTH-1:0];
  assign tag_a   = bus.addra[ADDR_WIDTH-1:INDEX_WIDTH];

  // A pending or live flush takes the IDLE cycle, so nothing is accepted
  // then. req_ready stays combinational on flush because a flush raised in
  // IDLE must block the request in that same cycle.
  assign flush_now       = (state_q == IDLE) && (bus.flush || flush_pend_q);
  assign accept          = (state_q == IDLE) && !flush_now && bus.req_valid;
  assign bus.req_ready   = (state_q == IDLE) && !flush_now && !rst;

  assign hit_d           = valid_q[idx_q] && (tag_rd_q == tag_q);
  assign wr_match        = bus.wea && (bus.addra == addr_q);
  assign accept_wr_match = bus.wea && (bus.addra == bus.req_addr);
  assign refill_fire     = (state_q == MWAIT) && bus.mem_resp_valid;

  // The snoop probes the tag array combinationally on addra so the update
  // lands in the same edge as the write. A refill to the same index replaces
  // the line, so the snoop write is dropped then; if the snoop targeted the
  // refilled address, the refill data already carries dina.
  assign snoop_hit       = bus.wea && valid_q[idx_a] && (tag_mem[idx_a] == tag_a);
  assign snoop_wr        = snoop_hit && !(refill_fire && (idx_a == idx_q));

  // Last write wins: a write in the refill edge beats an earlier latched
  // write, which beats the (stale) memory data.
  assign refill_data_d   = wr_match  ? bus.dina  :
                           wr_pend_q ? wr_data_q : bus.mem_resp_data;

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;

  // Tag and data arrays: synchronous-read RAMs with no reset. The lookup
  // read is taken at the accept edge; a snoop write to the requested address
  // in that same edge is forwarded so the read never returns the stale word.
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= refill_data_d;
    end
    if (snoop_wr) begin
      data_mem[idx_a] <= bus.dina;
    end
    if (accept) begin
      tag_rd_q  <= tag_mem[idx_req];
      data_rd_q <= accept_wr_match ? bus.dina : data_mem[idx_req];
    end
  end

  // Main controller with registered outputs. Snooped writes to the in-flight
  // address are captured in every busy state so the response and the refilled
  // line carry the newest data. A flush seen while busy is parked in
  // flush_pend_q and applied in the first IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      flush_pend_q    <= 1'b0;
      wr_pend_q       <= 1'b0;
      wr_data_q       <= '0;
      hit_data_q      <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
`ifdef DM_CACHE_STATS_EN
      hit_count       <= '0;
      miss_count      <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      if ((state_q != IDLE) && bus.flush) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (flush_now) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (bus.req_valid) begin
            addr_q    <= bus.req_addr;
            wr_pend_q <= accept_wr_match;
            wr_data_q <= bus.dina;
            state_q   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (wr_match) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= bus.dina;
          end
          if (hit_d) begin
            hit_data_q <= wr_match ? bus.dina : data_rd_q;
            state_q    <= RESP;
`ifdef DM_CACHE_STATS_EN
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= addr_q;
            state_q         <= MREQ;
`ifdef DM_CACHE_STATS_EN
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= wr_match ? bus.dina : hit_data_q;
          state_q      <= IDLE;
        end
        MREQ: begin
          if (wr_match) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= bus.dina;
          end
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MWAIT;
          end
        end
        MWAIT: begin
          if (wr_match) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= bus.dina;
          end
          if (bus.mem_resp_valid) begin
            valid_q[idx_q] <= 1'b1;
            resp_valid_q   <= 1'b1;
            resp_data_q    <= refill_data_d;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_read_cache.sv
// ---------------------------------------------------------------------------
// tb_dm_read_cache
// Directed bench for dm_read_cache. Expected response words are pushed to a
// queue when each request is issued and popped by a monitor on resp_valid.
// The bench plays the backing memory by hand for every refill.
// ---------------------------------------------------------------------------
module tb_dm_read_cache;
  localparam int DW = 32;
  localparam int AW = 19;
  localparam int IW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cycle;
  int   acceptCycle;
  int   lastLatency;
  int   memReqCount;
  logic [DW-1:0] expQ [$];

  dm_read_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  dm_read_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_count  (hitCount),
    .miss_count (missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter, accept timestamp and refill-request counter.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst && bus.req_valid && bus.req_ready) acceptCycle <= cycle + 1;
    if (!rst && bus.mem_req_valid && bus.mem_req_ready) memReqCount <= memReqCount + 1;
  end

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      checkOutput("resp_expected", expQ.size() != 0, 1);
      if (expQ.size() != 0) checkOutput("resp_data", bus.resp_data, expQ.pop_front());
      lastLatency = cycle - acceptCycle;
    end
  end

  // Issue one read; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    expQ.push_back(exp);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic memAccept(input logic [AW-1:0] addr);
    int n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mem_req_valid", bus.mem_req_valid, 1);
    checkOutput("mem_addr", bus.mem_addr, addr);
    @(negedge clk);
    checkOutput("mem_req_hold", {bus.mem_req_valid, bus.mem_addr}, {1'b1, addr});
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic memRespond(input logic [DW-1:0] data, input int delay);
    repeat (delay) @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = data;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic waitResp();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_pending", expQ.size(), 0);
  endtask

  task automatic snoop(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wea   = 1'b1;
    bus.addra = addr;
    bus.dina  = data;
    @(negedge clk);
    bus.wea   = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int m0, a1, a2;
    checks = 0; failures = 0; cycle = 0; acceptCycle = 0;
    lastLatency = 0; memReqCount = 0;
    bus.req_valid = 0; bus.req_addr = '0; bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.wea = 0;
    bus.addra = '0; bus.dina = '0; bus.flush = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_outputs", {bus.resp_valid, bus.mem_req_valid, bus.mem_addr, bus.resp_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", bus.req_ready, 1);
    @(negedge clk);

    $display("[TB] cold miss and hit");
    applyStimulus(19'h00105, 32'hDEADBEEF);
    memAccept(19'h00105);
    memRespond(32'hDEADBEEF, 3);
    waitResp();
    @(negedge clk);
    checkOutput("resp_pulse_hold", {bus.resp_valid, bus.resp_data}, {1'b0, 32'hDEADBEEF});
    m0 = memReqCount;
    applyStimulus(19'h00105, 32'hDEADBEEF);
    waitResp();
    checkOutput("hit_latency", lastLatency, 2);
    checkOutput("hit_no_mem", memReqCount, m0);
    applyStimulus(19'h00105, 32'hDEADBEEF);
    a1 = acceptCycle;
    applyStimulus(19'h00105, 32'hDEADBEEF);
    a2 = acceptCycle;
    waitResp();
    checkOutput("hit_throughput", a2 - a1, 3);

    $display("[TB] conflict");
    applyStimulus(19'h00205, 32'h11111111);
    memAccept(19'h00205);
    memRespond(32'h11111111, 1);
    waitResp();
    applyStimulus(19'h00105, 32'hDEADBEEF);
    memAccept(19'h00105);
    memRespond(32'hDEADBEEF, 2);
    waitResp();

    $display("[TB] snoop");
    applyStimulus(19'h00042, 32'hAAAA0000);
    memAccept(19'h00042);
    memRespond(32'hAAAA0000, 1);
    waitResp();
    snoop(19'h00042, 32'h12345678);
    m0 = memReqCount;
    applyStimulus(19'h00042, 32'h12345678);
    waitResp();
    checkOutput("snoop_hit_no_mem", memReqCount, m0);
    snoop(19'h00043, 32'h55555555);
    applyStimulus(19'h00043, 32'h43434343);
    memAccept(19'h00043);
    memRespond(32'h43434343, 1);
    waitResp();

    $display("[TB] write hazards");
    bus.wea = 1'b1; bus.addra = 19'h00042; bus.dina = 32'h99990001;
    applyStimulus(19'h00042, 32'h99990001);
    bus.wea = 1'b0;
    waitResp();
    applyStimulus(19'h00042, 32'h77770002);
    snoop(19'h00042, 32'h77770002);
    waitResp();
    m0 = memReqCount;
    applyStimulus(19'h00042, 32'h77770002);
    waitResp();
    checkOutput("lookup_wr_array", memReqCount, m0);
    applyStimulus(19'h00077, 32'hCAFEF00D);
    memAccept(19'h00077);
    snoop(19'h00077, 32'hCAFEF00D);
    memRespond(32'h0BADBAD0, 2);
    waitResp();
    m0 = memReqCount;
    applyStimulus(19'h00077, 32'hCAFEF00D);
    waitResp();
    checkOutput("miss_wr_line_hit", memReqCount, m0);

    $display("[TB] flush");
    pulseReset();
    applyStimulus(19'h00001, 32'h00000001);
    memAccept(19'h00001);
    memRespond(32'h00000001, 1);
    waitResp();
    applyStimulus(19'h00002, 32'h00000002);
    memAccept(19'h00002);
    memRespond(32'h00000002, 1);
    waitResp();
    applyStimulus(19'h00003, 32'h00000003);
    memAccept(19'h00003);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    memRespond(32'h00000003, 1);
    #1;
    checkOutput("flush_pend_ready", bus.req_ready, 0);
    waitResp();
    applyStimulus(19'h00001, 32'h00000001);
    memAccept(19'h00001);
    memRespond(32'h00000001, 1);
    waitResp();
    applyStimulus(19'h00002, 32'h00000002);
    memAccept(19'h00002);
    memRespond(32'h00000002, 1);
    waitResp();
`ifdef DM_CACHE_STATS_EN
    checkOutput("hit_count", hitCount, 0);
    checkOutput("miss_count", missCount, 5);
`endif
    bus.flush = 1'b1;
    #1;
    checkOutput("idle_flush_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    applyStimulus(19'h00002, 32'h22222222);
    memAccept(19'h00002);
    memRespond(32'h22222222, 1);
    waitResp();

    $display("[TB] reset mid-refill");
    applyStimulus(19'h00010, 32'h10101010);
    memAccept(19'h00010);
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("midrst_outputs", {bus.req_ready, bus.resp_valid, bus.mem_req_valid,
                                   bus.mem_addr, bus.resp_data}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h00000BAD;
    @(negedge clk);
    checkOutput("late_resp_ignored", {bus.resp_valid, bus.req_ready}, {1'b0, 1'b1});
    bus.mem_resp_valid = 1'b0;
    applyStimulus(19'h00010, 32'h10101010);
    memAccept(19'h00010);
    memRespond(32'h10101010, 1);
    waitResp();

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
